writeback_stage: RTL and testbench

Parametrised writeback stage for the BRISC-V core pipeline. It sits between the memory stage and the register file. Each cycle it selects the result among ALU, load data, PC+4 and CSR read data. It aligns and sign/zero-extends sub-word loads, registers the result for one cycle, and keeps a retired-instruction counter. Stall and flush insert bubbles, and writes to x0 are suppressed.

---
 rtl/writeback_pkg.sv | 23 ++
 rtl/writeback_load_align.sv | 45 ++++
 rtl/writeback_stage.sv | 115 +++++++++++
 tb/tb_writeback_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// Shared encodings for the writeback stage: source selects and load types.
// Pure definitions, no logic, no latency.
// Imported by writeback_stage and load_align.
package writeback_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2,
        WB_SEL_CSR = 2'd3
    } wb_sel_e;

    typedef enum logic [2:0] {
        LT_LB  = 3'd0,
        LT_LH  = 3'd1,
        LT_LW  = 3'd2,
        LT_LD  = 3'd3,
        LT_LBU = 3'd4,
        LT_LHU = 3'd5,
        LT_LWU = 3'd6
    } load_type_e;

endpackage

// File: rtl/writeback_load_align.sv
// Load alignment: shifts the addressed lane down and sign/zero-extends it.
// Purely combinational, zero latency.
// No backpressure; output follows inputs.
module load_align
    import writeback_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int OFFW = $clog2(DATA_WIDTH / 8)
) (
    input  logic [DATA_WIDTH-1:0] memory_data,
    input  logic [OFFW-1:0]       byte_offset,
    input  logic [2:0]            load_type,
    output logic [DATA_WIDTH-1:0] load_data
);

    localparam bit IS64 = (DATA_WIDTH == 64);

    logic [OFFW-1:0]       off;
    logic [DATA_WIDTH-1:0] lane;

    // Round the offset down to the access size, then extract and extend the lane.
    // On a 32-bit core LD, LWU and the unused encoding all collapse onto LW.
    always_comb begin
        off       = byte_offset;
        load_data = '0;
        case (load_type)
            LT_LB, LT_LBU: off = byte_offset;
            LT_LH, LT_LHU: off[0] = 1'b0;
            LT_LD:         off = IS64 ? '0 : '0;
            default:       off[1:0] = 2'b00;
        endcase
        lane = memory_data >> {off, 3'b000};
        case (load_type)
            LT_LB:   load_data = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
            LT_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
            LT_LH:   load_data = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
            LT_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
            LT_LD:   load_data = IS64 ? lane : DATA_WIDTH'($signed(lane[31:0]));
            LT_LWU:  load_data = IS64 ? DATA_WIDTH'(lane[31:0])
                                      : DATA_WIDTH'($signed(lane[31:0]));
            default: load_data = DATA_WIDTH'($signed(lane[31:0]));
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: source mux, load alignment, registered RF write, retire counter.
// One cycle latency: inputs accepted at edge N appear on the outputs after edge N.
// stall/flush insert a bubble (write=0, reg/data held); optional report via WRITEBACK_STAGE_REPORT_EN.
module writeback_stage
    import writeback_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int RETIRE_WIDTH = 32,
    localparam int OFFW = $clog2(DATA_WIDTH / 8)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    valid_in,
    input  logic                    opWrite,
    input  logic [1:0]              opSel,
    input  logic [2:0]              load_type,
    input  logic [OFFW-1:0]         byte_offset,
    input  logic [4:0]              opReg,
    input  logic [DATA_WIDTH-1:0]   ALU_Result,
    input  logic [DATA_WIDTH-1:0]   memory_data,
    input  logic [DATA_WIDTH-1:0]   pc_plus4,
    input  logic [DATA_WIDTH-1:0]   csr_data,
    output logic                    write,
    output logic [4:0]              write_reg,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [RETIRE_WIDTH-1:0] retired_count,
    input  logic                    report
);

    logic [DATA_WIDTH-1:0]   load_data;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    accept;
    logic                    write_q,  write_d;
    logic [4:0]              reg_q,    reg_d;
    logic [DATA_WIDTH-1:0]   data_q,   data_d;
    logic [RETIRE_WIDTH-1:0] retire_q, retire_d;

    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .memory_data (memory_data),
        .byte_offset (byte_offset),
        .load_type   (load_type),
        .load_data   (load_data)
    );

    // Pick the writeback source.
    always_comb begin
        sel_data = ALU_Result;
        case (opSel)
            WB_SEL_MEM: sel_data = load_data;
            WB_SEL_PC4: sel_data = pc_plus4;
            WB_SEL_CSR: sel_data = csr_data;
            default:    sel_data = ALU_Result;
        endcase
    end

    // Next state: accept loads the result, anything else is a bubble that holds reg/data.
    always_comb begin
        accept   = valid_in & ~stall & ~flush;
        write_d  = 1'b0;
        reg_d    = reg_q;
        data_d   = data_q;
        retire_d = retire_q;
        if (accept) begin
            write_d  = opWrite & (opReg != 5'd0);
            reg_d    = opReg;
            data_d   = sel_data;
            retire_d = retire_q + 1'b1;
        end
    end

    // Output and retire registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_q  <= 1'b0;
            reg_q    <= '0;
            data_q   <= '0;
            retire_q <= '0;
        end else begin
            write_q  <= write_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
            retire_q <= retire_d;
        end
    end

    assign write         = write_q;
    assign write_reg     = reg_q;
    assign write_data    = data_q;
    assign retired_count = retire_q;

`ifdef WRITEBACK_STAGE_REPORT_EN
    logic [31:0] cycle_q;

    // Free-running cycle counter and per-edge state report.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
        if (report) begin
            $display("[WB %0d] cycle=%0d opSel=%0d load_type=%0d opReg=%0d alu=%h mem=%h pc4=%h csr=%h write=%b write_reg=%0d write_data=%h retired=%0d",
                     CORE, cycle_q, opSel, load_type, opReg, ALU_Result, memory_data,
                     pc_plus4, csr_data, write_q, reg_q, data_q, retire_q);
        end
    end
`else
    logic unused_report;
    assign unused_report = report ^ (CORE != 0);
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    typedef struct packed {
        logic        w;
        logic [4:0]  r;
        logic [31:0] d;
        logic [3:0]  c;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset, stall, flush, valid_in, opWrite;
    logic [1:0]  opSel;
    logic [2:0]  load_type;
    logic [1:0]  byte_offset;
    logic [4:0]  opReg;
    logic [31:0] ALU_Result, memory_data, pc_plus4, csr_data;
    logic        write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [3:0]  retired_count;
    logic        report;

    exp_t sb[$];
    exp_t m;
    int   n_tests = 0;
    int   n_fail  = 0;

    writeback_stage #(.CORE(0), .DATA_WIDTH(32), .RETIRE_WIDTH(4)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .opWrite(opWrite), .opSel(opSel),
        .load_type(load_type), .byte_offset(byte_offset), .opReg(opReg),
        .ALU_Result(ALU_Result), .memory_data(memory_data),
        .pc_plus4(pc_plus4), .csr_data(csr_data),
        .write(write), .write_reg(write_reg), .write_data(write_data),
        .retired_count(retired_count), .report(report)
    );

    always #5 clock = ~clock;

    // Monitor: every edge the DUT presents a registered result; compare it with the queue head.
    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (write !== e.w) begin
                n_fail++;
                $display("FAIL write: got %b want %b", write, e.w);
            end
            n_tests++;
            if (write_reg !== e.r) begin
                n_fail++;
                $display("FAIL write_reg: got %0d want %0d", write_reg, e.r);
            end
            n_tests++;
            if (write_data !== e.d) begin
                n_fail++;
                $display("FAIL write_data: got %h want %h", write_data, e.d);
            end
            n_tests++;
            if (retired_count !== e.c) begin
                n_fail++;
                $display("FAIL retired_count: got %0d want %0d", retired_count, e.c);
            end
        end
    end

    task automatic ins(input logic v, input logic w, input logic [1:0] sel,
                       input logic [2:0] lt, input logic [1:0] off, input logic [4:0] rg);
        valid_in = v; opWrite = w; opSel = sel; load_type = lt;
        byte_offset = off; opReg = rg; stall = 1'b0; flush = 1'b0;
    endtask

    // One cycle: push the expected post-edge state, then advance to the next negedge.
    // exp_d is the hand-computed data value if this cycle's input gets accepted.
    task automatic cyc(input logic [31:0] exp_d);
        if (reset) begin
            m = '0;
        end else if (valid_in && !stall && !flush) begin
            m.w = opWrite && (opReg != 5'd0);
            m.r = opReg;
            m.d = exp_d;
            m.c = m.c + 4'd1;
        end else begin
            m.w = 1'b0;
        end
        sb.push_back(m);
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        m = '0;
        reset = 1'b1; report = 1'b0;
        ALU_Result = 32'h0; memory_data = 32'h0; pc_plus4 = 32'h0; csr_data = 32'h0;
        ins(0, 0, 0, 0, 0, 0);

        // Reset held 3 cycles, then idle
        repeat (3) cyc(32'h0);
        reset = 1'b0;
        cyc(32'h0);

        // ALU writes, then the same to x0
        ALU_Result = 32'h1234;
        ins(1, 1, 0, 0, 0, 5); cyc(32'h0000_1234);
        ins(1, 1, 0, 0, 0, 0); cyc(32'h0000_1234);

        // Loads from 0x80FF7F01
        memory_data = 32'h80FF_7F01;
        ins(1, 1, 1, 3'd0, 2'd3, 6); cyc(32'hFFFF_FF80);  // LB  +3
        ins(1, 1, 1, 3'd4, 2'd3, 6); cyc(32'h0000_0080);  // LBU +3
        ins(1, 1, 1, 3'd1, 2'd2, 7); cyc(32'hFFFF_80FF);  // LH  +2
        ins(1, 1, 1, 3'd5, 2'd3, 7); cyc(32'h0000_80FF);  // LHU +3 -> +2
        ins(1, 1, 1, 3'd2, 2'd0, 8); cyc(32'h80FF_7F01);  // LW
        ins(1, 1, 1, 3'd0, 2'd1, 8); cyc(32'h0000_007F);  // LB  +1
        ins(1, 1, 1, 3'd1, 2'd1, 9); cyc(32'h0000_7F01);  // LH  +1 -> +0
        ins(1, 1, 1, 3'd2, 2'd3, 9); cyc(32'h80FF_7F01);  // LW  +3 -> +0
        ins(1, 1, 1, 3'd3, 2'd2, 10); cyc(32'h80FF_7F01); // LD as LW
        ins(1, 1, 1, 3'd6, 2'd1, 10); cyc(32'h80FF_7F01); // LWU as LW
        ins(1, 1, 1, 3'd7, 2'd2, 11); cyc(32'h80FF_7F01); // 7 as LW

        // Stall on 2nd, flush on 3rd after a fresh reset: writes 1,0,0,1 and count 2
        reset = 1'b1; cyc(32'h0); reset = 1'b0;
        ALU_Result = 32'h11; ins(1, 1, 0, 0, 0, 3); cyc(32'h11);
        ALU_Result = 32'h22; ins(1, 1, 0, 0, 0, 4); stall = 1'b1; cyc(32'h22);
        ALU_Result = 32'h33; ins(1, 1, 0, 0, 0, 5); flush = 1'b1; cyc(32'h33);
        ALU_Result = 32'h44; ins(1, 1, 0, 0, 0, 6); cyc(32'h44);
        // stall and flush together
        ALU_Result = 32'h55; ins(1, 1, 0, 0, 0, 7); stall = 1'b1; flush = 1'b1; cyc(32'h55);
        // store-like accept with opWrite=0 still counts
        ins(1, 0, 0, 0, 0, 12); cyc(32'h55);

        // PC+4 and CSR sources
        pc_plus4 = 32'h104; ins(1, 1, 2, 0, 0, 1); cyc(32'h0000_0104);
        csr_data = 32'hDEAD; ins(1, 1, 3, 0, 0, 2); cyc(32'h0000_DEAD);

        // 17 back-to-back accepts from reset wrap the 4-bit counter to 1
        reset = 1'b1; ins(0, 0, 0, 0, 0, 0); cyc(32'h0); reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            ALU_Result = 32'h100 + i;
            ins(1, 1, 0, 0, 0, 5'(i + 1));
            cyc(32'h100 + i);
        end
        n_tests++;
        if (retired_count !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d want 1", retired_count);
        end

        // Reset during a valid write discards it
        ALU_Result = 32'hBEEF; ins(1, 1, 0, 0, 0, 9); reset = 1'b1; cyc(32'hBEEF);
        reset = 1'b0;
        ins(1, 1, 0, 0, 0, 9); cyc(32'hBEEF);   // first accept after reset counts as 1
        ins(0, 0, 0, 0, 0, 0); cyc(32'h0);

        @(posedge clock); #2;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
